// File: rtl/dmem_lsu_pkg.sv
// Shared encodings and helpers for the dmem_lsu load/store unit.
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational byte lane logic: load extract/extend and store merge.
// Field of interest always sits at the top of the 64-bit word (big-endian lanes).
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    input  logic [63:0] rd_q,
    output logic [63:0] ld_data,
    output logic [63:0] st_data
);

    logic [6:0]  shamt;
    logic [63:0] keep_mask;

    function automatic logic [63:0] ext_load(input logic [63:0] word,
                                             input logic [6:0]  sh,
                                             input logic        z);
        logic signed [63:0] word_s;
        word_s = signed'(word);
        if (z)
            return word >> sh;
        return word_s >>> sh;
    endfunction

    // shamt is the number of bit positions below the accessed field.
    assign shamt     = 7'd64 - {size_bytes(size), 3'b000};
    assign keep_mask = ~(~64'd0 << shamt);
    assign ld_data   = ext_load(rdata, shamt, zext);
    assign st_data   = (wdata << shamt) | (rd_q & keep_mask);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between MEM stage and 64-bit byte-addressed data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: accesses with addr mod size != 0 also fault.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int XLEN      = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rw,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [XLEN:0] LAST_OK = (XLEN+1)'(MEM_BYTES - 8);

    state_t          state;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rd_q;
    logic [XLEN-1:0] res_q;
    logic            fault_q;

    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] st_data;
    logic            req_fault;

    // Every access touches 8 bytes, so the bound ignores the request size.
`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] align_mask;
    assign align_mask = 3'(size_bytes(req_size) - 4'd1);
    assign req_fault  = ({1'b0, req_addr} > LAST_OK) || (|(req_addr[2:0] & align_mask));
`else
    assign req_fault  = ({1'b0, req_addr} > LAST_OK);
`endif

    dmem_lsu_align u_align (
        .size    (size_q),
        .zext    (uns_q),
        .rdata   (mem_rdata),
        .wdata   (wdata_q),
        .rd_q    (rd_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        res_q   <= '0;
                        fault_q <= req_fault;
                        if (req_fault)
                            state <= RESP;
                        else if (!req_we)
                            state <= LOAD;
                        else if (req_size == SZ_D)
                            state <= WRITE;
                        else
                            state <= RMW_RD;
                    end
                end
                LOAD: begin
                    res_q <= ld_data;
                    state <= RESP;
                end
                RMW_RD: begin
                    rd_q  <= mem_rdata;
                    state <= WRITE;
                end
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side signals are pure decodes of state, so a reset in WRITE
    // leaves the falling-edge write of that cycle intact.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_fault = resp_valid && fault_q;
    assign resp_rdata = (resp_valid && !we_q) ? res_q : '0;
    assign mem_rw     = (state == WRITE);
    assign mem_addr   = (state == LOAD || state == RMW_RD || state == WRITE) ? addr_q : '0;
    assign mem_wdata  = (state == WRITE) ? st_data : '0;

endmodule
